axil_master: RTL and testbench

AXIL_MASTER -- requirements
Module: axil_master

---
 rtl/axil_master_if.sv | 49 ++++
 rtl/axil_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axil_master.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_master_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_master_if
// Purpose  : AXI4-Lite bus bundle between a single master and a single slave.
//            Carries the AW, W, B, AR and R channel signals.
// Params   : ADDR_W - address width, DATA_W - data width (8/16/32/64)
// Modports : master - drives addresses, data, valids and response readies
//            slave  - drives address/data readies, responses and read data
// Revision : 1.0 - initial release
// ============================================================================
interface axil_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axil_master.sv
`default_nettype none
// ============================================================================
// Module   : axil_master
// Purpose  : Single-outstanding AXI4-Lite master. A user write request and a
//            user read request are turned into AXI-Lite transactions by two
//            independent state machines that may run concurrently. Every
//            output is registered. A saturating counter tracks non-OKAY
//            responses from both channels.
// Params   : ADDR_W - address width, DATA_W - data width (8/16/32/64)
// Ports    : clk, rst (synchronous, active-high)
//            wr_req/wr_addr/wr_data/wr_strb -> wr_ready, wr_done, wr_resp
//            rd_req/rd_addr                 -> rd_ready, rd_done, rd_data,
//                                              rd_resp
//            err_cnt                        -  saturating error count
//            axi                            -  AXI4-Lite master modport
// Revision : 1.0 - initial release
// ============================================================================
module axil_master #(
    parameter  int ADDR_W = 4,
    parameter  int DATA_W = 8,
    localparam int STRB_W = DATA_W / 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    // user write side
    input  wire logic              wr_req,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic [STRB_W-1:0] wr_strb,
    output logic                   wr_ready,
    output logic                   wr_done,
    output logic [1:0]             wr_resp,
    // user read side
    input  wire logic              rd_req,
    input  wire logic [ADDR_W-1:0] rd_addr,
    output logic                   rd_ready,
    output logic                   rd_done,
    output logic [DATA_W-1:0]      rd_data,
    output logic [1:0]             rd_resp,
    // status
    output logic [7:0]             err_cnt,
    // AXI4-Lite bus
    axil_master_if.master          axi
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_SEND = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [1:0]        r_wstate;
    logic              r_wr_ready;
    logic              r_wr_done;
    logic [1:0]        r_wr_resp;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_awvalid;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_wvalid;
    logic              r_bready;

    logic [1:0]        r_rstate;
    logic              r_rd_ready;
    logic              r_rd_done;
    logic [DATA_W-1:0] r_rd_data;
    logic [1:0]        r_rd_resp;
    logic [ADDR_W-1:0] r_araddr;
    logic              r_arvalid;
    logic              r_rready;

    logic [7:0]        r_err_cnt;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_clear;
    logic w_w_clear;

    assign w_aw_hs = r_awvalid & axi.awready;
    assign w_w_hs  = r_wvalid  & axi.wready;
    assign w_b_hs  = r_bready  & axi.bvalid;
    assign w_ar_hs = r_arvalid & axi.arready;
    assign w_r_hs  = r_rready  & axi.rvalid;

    // A channel counts as finished when its valid is already low or it
    // completes its handshake this cycle, so AW and W may finish in any
    // order or together.
    assign w_aw_clear = ~r_awvalid | axi.awready;
    assign w_w_clear  = ~r_wvalid  | axi.wready;

    // ------------------------------------------------------------------
    // Write state machine
    // ready is held low during the done-pulse cycle so a request that
    // coincides with wr_done is not taken; it rises one cycle later.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate   <= W_IDLE;
            r_wr_ready <= 1'b1;
            r_wr_done  <= 1'b0;
            r_wr_resp  <= 2'b00;
            r_awaddr   <= '0;
            r_awvalid  <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (!r_wr_ready) begin
                        r_wr_ready <= 1'b1;
                    end else if (wr_req) begin
                        r_awaddr   <= wr_addr;
                        r_wdata    <= wr_data;
                        r_wstrb    <= wr_strb;
                        r_awvalid  <= 1'b1;
                        r_wvalid   <= 1'b1;
                        r_wr_ready <= 1'b0;
                        r_wstate   <= W_SEND;
                    end
                end
                W_SEND: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_clear && w_w_clear) begin
                        r_bready <= 1'b1;
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bready  <= 1'b0;
                        r_wr_done <= 1'b1;
                        r_wr_resp <= axi.bresp;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: begin
                    r_wstate   <= W_IDLE;
                    r_wr_ready <= 1'b1;
                    r_awvalid  <= 1'b0;
                    r_wvalid   <= 1'b0;
                    r_bready   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read state machine (same ready/done relationship as the write side)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate   <= R_IDLE;
            r_rd_ready <= 1'b1;
            r_rd_done  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_resp  <= 2'b00;
            r_araddr   <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
        end else begin
            r_rd_done <= 1'b0;
            case (r_rstate)
                R_IDLE: begin
                    if (!r_rd_ready) begin
                        r_rd_ready <= 1'b1;
                    end else if (rd_req) begin
                        r_araddr   <= rd_addr;
                        r_arvalid  <= 1'b1;
                        r_rd_ready <= 1'b0;
                        r_rstate   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        r_rready  <= 1'b0;
                        r_rd_done <= 1'b1;
                        r_rd_data <= axi.rdata;
                        r_rd_resp <= axi.rresp;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: begin
                    r_rstate   <= R_IDLE;
                    r_rd_ready <= 1'b1;
                    r_arvalid  <= 1'b0;
                    r_rready   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Saturating error counter; both channels can report in one cycle.
    // ------------------------------------------------------------------
    logic       w_wr_err;
    logic       w_rd_err;
    logic [1:0] w_err_inc;
    logic [8:0] w_err_sum;

    assign w_wr_err  = (r_wstate == W_RESP) && w_b_hs && (axi.bresp != 2'b00);
    assign w_rd_err  = (r_rstate == R_DATA) && w_r_hs && (axi.rresp != 2'b00);
    assign w_err_inc = {1'b0, w_wr_err} + {1'b0, w_rd_err};
    assign w_err_sum = {1'b0, r_err_cnt} + {7'd0, w_err_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_err_sum[8]) begin
            r_err_cnt <= 8'hFF;
        end else begin
            r_err_cnt <= w_err_sum[7:0];
        end
    end

    // ------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------
    assign wr_ready    = r_wr_ready;
    assign wr_done     = r_wr_done;
    assign wr_resp     = r_wr_resp;
    assign rd_ready    = r_rd_ready;
    assign rd_done     = r_rd_done;
    assign rd_data     = r_rd_data;
    assign rd_resp     = r_rd_resp;
    assign err_cnt     = r_err_cnt;

    assign axi.awaddr  = r_awaddr;
    assign axi.awvalid = r_awvalid;
    assign axi.wdata   = r_wdata;
    assign axi.wstrb   = r_wstrb;
    assign axi.wvalid  = r_wvalid;
    assign axi.bready  = r_bready;
    assign axi.araddr  = r_araddr;
    assign axi.arvalid = r_arvalid;
    assign axi.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_master
// Purpose  : Directed self-checking bench for axil_master (DATA_W=32).
//            A small reactive slave answers AW/W with B and AR with R; the
//            bench controls the address/data readies and response codes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_master;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_ready;
    logic              wr_done;
    logic [1:0]        wr_resp;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_resp;
    logic [7:0]        err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // slave controls
    logic              b_hold;
    logic [1:0]        b_resp_val;
    logic [1:0]        r_resp_val;
    logic [DATA_W-1:0] r_data_val;
    logic              aw_seen;
    logic              w_seen;

    axil_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    axil_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .wr_ready (wr_ready),
        .wr_done  (wr_done),
        .wr_resp  (wr_resp),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_ready (rd_ready),
        .rd_done  (rd_done),
        .rd_data  (rd_data),
        .rd_resp  (rd_resp),
        .err_cnt  (err_cnt),
        .axi      (axi)
    );

    always #5 clk = ~clk;

    // Reactive slave: B is raised the edge both AW and W are accepted,
    // R is raised the edge AR is accepted.
    logic a_now;
    logic d_now;
    assign a_now = aw_seen | (axi.awvalid & axi.awready);
    assign d_now = w_seen  | (axi.wvalid  & axi.wready);

    always @(posedge clk) begin
        if (rst) begin
            axi.bvalid <= 1'b0;
            axi.bresp  <= 2'b00;
            axi.rvalid <= 1'b0;
            axi.rresp  <= 2'b00;
            axi.rdata  <= '0;
            aw_seen    <= 1'b0;
            w_seen     <= 1'b0;
        end else begin
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;
            if (a_now && d_now && !b_hold && !axi.bvalid) begin
                axi.bvalid <= 1'b1;
                axi.bresp  <= b_resp_val;
                aw_seen    <= 1'b0;
                w_seen     <= 1'b0;
            end else begin
                aw_seen <= a_now;
                w_seen  <= d_now;
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
            if (axi.arvalid && axi.arready) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= r_data_val;
                axi.rresp  <= r_resp_val;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Issue a write and/or read in the same cycle and wait for completion.
    task automatic run_txn(input logic do_w, input logic do_r);
        logic wseen;
        logic rseen;
        wr_req  = do_w;
        rd_req  = do_r;
        wr_addr = 4'h1;
        rd_addr = 4'h2;
        tick();
        wr_req = 1'b0;
        rd_req = 1'b0;
        wseen  = !do_w;
        rseen  = !do_r;
        for (int k = 0; k < 20 && !(wseen && rseen); k++) begin
            tick();
            if (wr_done) wseen = 1'b1;
            if (rd_done) rseen = 1'b1;
        end
        check("txn_done", {62'd0, wseen, rseen}, 64'd3);
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_strb    = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        b_hold     = 1'b0;
        b_resp_val = 2'b00;
        r_resp_val = 2'b00;
        r_data_val = '0;
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.arready = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) tick();
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid",  axi.wvalid,  1'b0);
        check("rst_bready",  axi.bready,  1'b0);
        check("rst_arvalid", axi.arvalid, 1'b0);
        check("rst_rready",  axi.rready,  1'b0);
        check("rst_wr_ready", wr_ready, 1'b1);
        check("rst_rd_ready", rd_ready, 1'b1);
        check("rst_done", {wr_done, rd_done}, 2'b00);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_err_cnt", err_cnt, 8'd0);
        rst = 1'b0;
        tick();

        // ---------------- basic write, always-ready ----------------
        wr_req = 1'b1; wr_addr = 4'h3; wr_data = 32'hDEADBEEF; wr_strb = 4'hF;
        tick();                                   // N+1
        wr_req = 1'b0; wr_data = 32'h0; wr_addr = 4'h0; wr_strb = 4'h0;
        check("a1_awvalid", axi.awvalid, 1'b1);
        check("a1_wvalid",  axi.wvalid,  1'b1);
        check("a1_awaddr",  axi.awaddr,  4'h3);
        check("a1_wdata",   axi.wdata,   32'hDEADBEEF);
        check("a1_wstrb",   axi.wstrb,   4'hF);
        check("a1_wr_ready", wr_ready, 1'b0);
        check("a1_bready",  axi.bready,  1'b0);
        tick();                                   // N+2
        check("a2_valids", {axi.awvalid, axi.wvalid}, 2'b00);
        check("a2_bready", axi.bready, 1'b1);
        check("a2_wr_done", wr_done, 1'b0);
        tick();                                   // N+3
        check("a3_wr_done", wr_done, 1'b1);
        check("a3_wr_resp", wr_resp, 2'b00);
        check("a3_bready",  axi.bready, 1'b0);
        check("a3_wr_ready", wr_ready, 1'b0);
        tick();
        check("a4_wr_done", wr_done, 1'b0);
        check("a4_wr_ready", wr_ready, 1'b1);

        // ---------------- delayed awready ----------------
        axi.awready = 1'b0;
        wr_req = 1'b1; wr_addr = 4'hC; wr_data = 32'h12345678; wr_strb = 4'h5;
        tick();                                   // N+1
        wr_req = 1'b0;
        check("b1_valids", {axi.awvalid, axi.wvalid}, 2'b11);
        tick();                                   // N+2
        check("b2_wvalid",  axi.wvalid,  1'b0);
        check("b2_awvalid", axi.awvalid, 1'b1);
        check("b2_bready",  axi.bready,  1'b0);
        wr_req = 1'b1; wr_addr = 4'h9;            // must be ignored while busy
        tick();                                   // N+3
        wr_req = 1'b0;
        check("b3_awvalid", axi.awvalid, 1'b1);
        check("b3_awaddr",  axi.awaddr,  4'hC);
        check("b3_bready",  axi.bready,  1'b0);
        tick();                                   // N+4
        check("b4_awvalid", axi.awvalid, 1'b1);
        check("b4_bready",  axi.bready,  1'b0);
        axi.awready = 1'b1;
        tick();                                   // N+5
        check("b5_awvalid", axi.awvalid, 1'b0);
        check("b5_bready",  axi.bready,  1'b1);
        tick();                                   // N+6
        check("b6_wr_done", wr_done, 1'b1);
        wr_req = 1'b1; wr_addr = 4'h7;            // coincides with done: ignored
        tick();
        wr_req = 1'b0;
        check("b7_awvalid", axi.awvalid, 1'b0);
        check("b7_wr_ready", wr_ready, 1'b1);
        tick();
        check("b8_awvalid", axi.awvalid, 1'b0);
        check("b8_wr_done", wr_done, 1'b0);

        // ---------------- read with SLVERR ----------------
        r_data_val = 32'hA5; r_resp_val = 2'b10;
        rd_req = 1'b1; rd_addr = 4'h5;
        tick();                                   // N+1
        rd_req = 1'b0; rd_addr = 4'h0;
        check("c1_arvalid", axi.arvalid, 1'b1);
        check("c1_araddr",  axi.araddr,  4'h5);
        check("c1_rd_ready", rd_ready, 1'b0);
        tick();                                   // N+2
        check("c2_arvalid", axi.arvalid, 1'b0);
        check("c2_rready",  axi.rready,  1'b1);
        check("c2_err_cnt", err_cnt, 8'd0);
        tick();                                   // N+3
        check("c3_rd_done", rd_done, 1'b1);
        check("c3_rd_data", rd_data, 32'hA5);
        check("c3_rd_resp", rd_resp, 2'b10);
        check("c3_err_cnt", err_cnt, 8'd1);
        check("c3_rready",  axi.rready, 1'b0);
        r_data_val = 32'h0;
        tick();
        check("c4_rd_done", rd_done, 1'b0);
        check("c4_rd_data_hold", rd_data, 32'hA5);

        // ---------------- concurrent write + read, both errors ----------
        b_resp_val = 2'b11; r_resp_val = 2'b01; r_data_val = 32'hCAFE0001;
        wr_req = 1'b1; wr_addr = 4'h2; wr_data = 32'h55; wr_strb = 4'h1;
        rd_req = 1'b1; rd_addr = 4'h8;
        tick();
        wr_req = 1'b0; rd_req = 1'b0;
        check("d1_valids", {axi.awvalid, axi.wvalid, axi.arvalid}, 3'b111);
        tick();
        check("d2_readies", {axi.bready, axi.rready}, 2'b11);
        tick();
        check("d3_dones", {wr_done, rd_done}, 2'b11);
        check("d3_resps", {wr_resp, rd_resp}, 4'b1101);
        check("d3_rd_data", rd_data, 32'hCAFE0001);
        check("d3_err_cnt", err_cnt, 8'd3);
        tick();

        // ---------------- reset while waiting for B ----------------
        b_hold = 1'b1; b_resp_val = 2'b10;
        wr_req = 1'b1; wr_addr = 4'h4; wr_data = 32'h1; wr_strb = 4'h1;
        tick();
        wr_req = 1'b0;
        tick();                                   // W_RESP
        check("e2_bready", axi.bready, 1'b1);
        rst = 1'b1;
        tick();
        check("e3_bready",   axi.bready, 1'b0);
        check("e3_wr_ready", wr_ready, 1'b1);
        check("e3_wr_done",  wr_done, 1'b0);
        check("e3_err_cnt",  err_cnt, 8'd0);
        rst = 1'b0; b_hold = 1'b0;
        tick();
        check("e4_wr_done", wr_done, 1'b0);

        // ---------------- saturation ----------------
        b_resp_val = 2'b10; r_resp_val = 2'b10;
        for (int i = 0; i < 127; i++) run_txn(1'b1, 1'b1);
        check("f_err_254", err_cnt, 8'd254);
        run_txn(1'b1, 1'b0);
        check("f_err_255", err_cnt, 8'd255);
        run_txn(1'b1, 1'b1);
        check("f_sat_pair", err_cnt, 8'd255);
        run_txn(1'b0, 1'b1);
        check("f_sat_rd", err_cnt, 8'd255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
